alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised ALU for the pipelined CPU's execute stage. Performs the same operation set as the combinational execute-stage ALU at configurable data width. Registers every result behind a valid/ready handshake. Replaces the single-cycle multiplier with an iterative shift-add unit so MUL no longer sets the critical path; the pipeline stalls on ready_o/valid_o.

## Interface
- WIDTH, 32, operand/result width in bits (power of two, ≥ 8)
- SHW, $clog2(WIDTH), shift-amount bits taken from mux_i (derived, not overridden)

- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  reset, synchronous, active-low
- valid_i  input  1  request valid
- ready_o  output  1  block can accept a request this cycle
- ALUCtrl_i  input  3  operation, encoded with the shared `*_ALUCtrl` defines (ADD, SUB, AND, XOR, SLL, MUL, SRAI)
- reg_i  input  WIDTH  operand A, signed
- mux_i  input  WIDTH  operand B, signed
- ALU_o  output  WIDTH  registered result
- zero_o  output  1  ALU_o == 0, registered with ALU_o
- valid_o  output  1  result valid
- ready_i  input  1  downstream consumes result

## Operation
- States: IDLE, MUL, DONE.
- Accept = valid_i && ready_o. On accept, latch ALUCtrl_i, reg_i and mux_i. Later input changes are ignored until the next accept.
- ready_o = (state==IDLE) || (state==DONE && ready_i). Combinational from state and ready_i.
- IDLE, accept of non-MUL op: compute and register ALU_o and zero_o; go to DONE.
- IDLE, accept of MUL: load multiplicand = A, multiplier = B, acc = 0, count = 0; go to MUL.
- MUL, each cycle:
  - if multiplier[0], acc += multiplicand (mod 2^WIDTH)
  - multiplicand <<= 1; multiplier >>= 1; count++
  - after WIDTH iterations: ALU_o = acc; go to DONE
- DONE: valid_o = 1; ALU_o and zero_o held stable.
  - ready_i = 0: stay in DONE.
  - ready_i = 1 with no accept: go to IDLE.
  - ready_i = 1 with accept: process the new request exactly as from IDLE (back-to-back).
- Arithmetic:
  - ADD, SUB, MUL wrap mod 2^WIDTH; no overflow flag.
  - MUL returns the low WIDTH bits of the product, which are identical for signed and unsigned operands.
  - SLL is a logical left shift; SRAI is an arithmetic right shift (sign-fill). Both shift by mux_i[SHW-1:0]; upper bits of mux_i are ignored.
  - AND and XOR are bitwise.
  - An undefined ALUCtrl code yields ALU_o = 0, zero_o = 1, with single-op latency.
- valid_i while ready_o = 0 is ignored. The requester must hold valid_i until it is accepted.

## Timing
- Reset (rst_i low at an edge), from any state including mid-MUL:
  - state = IDLE; valid_o = 0; ALU_o = 0; zero_o = 0; counter and accumulator cleared.
  - An in-flight operation is discarded; no result appears after reset is released.
- ready_o is 1 in the first cycle after reset release.
- Non-MUL latency: accept at edge E, valid_o = 1 from after edge E until the consuming edge.
- MUL latency: accept at edge E, valid_o = 1 after edge E+WIDTH. The block spends WIDTH cycles in MUL; ready_o = 0 throughout.
- Sustained non-MUL throughput with ready_i = 1 is one result per cycle.
- valid_o falls at the edge where valid_o && ready_i, unless a new request is accepted at that same edge.

## Test plan
- Reset: drive rst_i = 0 for 2 cycles with valid_i = 1 → valid_o = 0, ALU_o = 0, zero_o = 0; ready_o = 1 in the cycle after rst_i rises.
- Single ops, WIDTH=32, ready_i = 1, each result one cycle after accept:
  - ADD 0x7FFFFFFF + 1 → 0x80000000
  - SUB 5 − 5 → 0, zero_o = 1
  - SRAI 0x80000000 by 4 → 0xF8000000
  - SLL 1 by mux_i = 0x21 → 0x00000002
- MUL, WIDTH=32: −3 × 7 → 0xFFFFFFEB, valid_o exactly 32 edges after accept, ready_o low for 32 cycles. WIDTH=8: 0x10 × 0x10 → 0x00, zero_o = 1.
- Backpressure: hold ready_i = 0 for 5 cycles after an ADD result appears → ALU_o, zero_o and valid_o stable and ready_o = 0; then raise ready_i together with a new XOR 0xF0 ^ 0xFF request → 0x0F appears on the next cycle.
- Back-to-back: 4 consecutive ADDs with valid_i = 1 and ready_i = 1 → 4 results on 4 consecutive cycles, in order.
- Reset mid-MUL: assert rst_i at cycle 10 of a MUL → valid_o stays 0 and no stale result appears; a subsequent ADD 2 + 3 returns 5.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the execute stage, results behind valid/ready.
// MUL is an iterative shift-add unit taking WIDTH cycles; other ops take one.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-low reset
//   valid_i, ready_o   request handshake
//   ALUCtrl_i          operation code
//   reg_i, mux_i       operands A and B
//   ALU_o, zero_o      registered result and its zero flag
//   valid_o, ready_i   result handshake
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] reg_i,
  input  logic [WIDTH-1:0] mux_i,
  output logic [WIDTH-1:0] ALU_o,
  output logic             zero_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SRAI = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] acc_sum;

  assign ready_o = (state_q == S_IDLE) ||
                   ((state_q == S_DONE) && ready_i);
  assign accept  = valid_i && ready_o;
  assign shamt   = mux_i[SHW-1:0];

  assign ALU_o   = alu_q;
  assign zero_o  = zero_q;
  assign valid_o = valid_q;

  always_comb begin
    single_res = '0;
    case (ALUCtrl_i)
      OP_ADD:  single_res = reg_i + mux_i;
      OP_SUB:  single_res = reg_i - mux_i;
      OP_AND:  single_res = reg_i & mux_i;
      OP_XOR:  single_res = reg_i ^ mux_i;
      OP_SLL:  single_res = reg_i << shamt;
      OP_SRAI: single_res = $signed(reg_i) >>> shamt;
      default: single_res = '0;
    endcase
  end

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    alu_d    = alu_q;
    zero_d   = zero_q;
    valid_d  = valid_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          alu_d   = acc_sum;
          zero_d  = (acc_sum == '0);
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        if (accept) begin
          if (ALUCtrl_i == OP_MUL) begin
            mcand_d  = reg_i;
            mplier_d = mux_i;
            acc_d    = '0;
            cnt_d    = '0;
            valid_d  = 1'b0;
            state_d  = S_MUL;
          end else begin
            alu_d   = single_res;
            zero_d  = (single_res == '0);
            valid_d = 1'b1;
            state_d = S_DONE;
          end
        end else if (state_q == S_DONE && ready_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      alu_q    <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      alu_q    <= alu_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed checks of alu_mc at WIDTH=32 and WIDTH=8.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_alu_mc;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SUB  = 3'b001;
  localparam logic [2:0] AND_ = 3'b010;
  localparam logic [2:0] XOR_ = 3'b011;
  localparam logic [2:0] SLL  = 3'b100;
  localparam logic [2:0] MUL  = 3'b101;
  localparam logic [2:0] SRAI = 3'b110;
  localparam logic [2:0] UNDF = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [2:0]  ctrl = ADD;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready_o, zero_o, valid_o;
  logic [31:0] alu_o;

  logic        valid8 = 1'b0;
  logic        ready8_i = 1'b1;
  logic [2:0]  ctrl8 = ADD;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        ready8_o, zero8_o, valid8_o;
  logic [7:0]  alu8_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .valid_i(valid_i), .ready_o(ready_o),
    .ALUCtrl_i(ctrl), .reg_i(a), .mux_i(b),
    .ALU_o(alu_o), .zero_o(zero_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst),
    .valid_i(valid8), .ready_o(ready8_o),
    .ALUCtrl_i(ctrl8), .reg_i(a8), .mux_i(b8),
    .ALU_o(alu8_o), .zero_o(zero8_o),
    .valid_o(valid8_o), .ready_i(ready8_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    valid_i = 1'b1;
    ctrl = ADD; a = 32'd1; b = 32'd1;
    tick();
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      $display("FAIL reset_valid got=%b want=0", valid_o);
      errors++;
    end
    checks++;
    if (alu_o !== 32'h0) begin
      $display("FAIL reset_alu got=%h want=0", alu_o);
      errors++;
    end
    checks++;
    if (zero_o !== 1'b0) begin
      $display("FAIL reset_zero got=%b want=0", zero_o);
      errors++;
    end
    valid_i = 1'b0;
    rst = 1'b1;
    checks++;
    if (ready_o !== 1'b1) begin
      $display("FAIL reset_ready got=%b want=1", ready_o);
      errors++;
    end
  endtask

  task automatic test_single();
    logic [2:0]  op [6];
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] ex [6];
    op[0] = ADD;  va[0] = 32'h7FFFFFFF; vb[0] = 32'h1;
    ex[0] = 32'h80000000;
    op[1] = SUB;  va[1] = 32'd5; vb[1] = 32'd5;
    ex[1] = 32'h0;
    op[2] = SRAI; va[2] = 32'h80000000; vb[2] = 32'd4;
    ex[2] = 32'hF8000000;
    op[3] = SLL;  va[3] = 32'h1; vb[3] = 32'h21;
    ex[3] = 32'h2;
    op[4] = AND_; va[4] = 32'h0000F0F0; vb[4] = 32'h00000FF0;
    ex[4] = 32'h000000F0;
    op[5] = UNDF; va[5] = 32'd5; vb[5] = 32'd9;
    ex[5] = 32'h0;
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid_i = 1'b1;
      ctrl = op[i]; a = va[i]; b = vb[i];
      tick();
      valid_i = 1'b0;
      a = 32'hDEADBEEF; b = 32'h12345678;
      checks++;
      if (valid_o !== 1'b1 || alu_o !== ex[i] ||
          zero_o !== (ex[i] == 32'h0)) begin
        $display("FAIL single_%0d got=%h/z%b/v%b want=%h/z%b/v1",
                 i, alu_o, zero_o, valid_o, ex[i], ex[i] == 32'h0);
        errors++;
      end
    end
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      $display("FAIL single_drain got=%b want=0", valid_o);
      errors++;
    end
  endtask

  task automatic test_mul();
    ready_i = 1'b1;
    valid_i = 1'b1;
    ctrl = MUL; a = 32'hFFFFFFFD; b = 32'd7;
    tick();
    valid_i = 1'b0;
    a = 32'h55555555; b = 32'hAAAAAAAA; ctrl = ADD;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
        $display("FAIL mul_busy_%0d got=r%b/v%b want=r0/v0",
                 i, ready_o, valid_o);
        errors++;
      end
      tick();
    end
    checks++;
    if (valid_o !== 1'b1 || alu_o !== 32'hFFFFFFEB || zero_o !== 1'b0) begin
      $display("FAIL mul32 got=%h/z%b/v%b want=ffffffeb/z0/v1",
               alu_o, zero_o, valid_o);
      errors++;
    end
    tick();
  endtask

  task automatic test_mul8();
    logic [7:0] va [2];
    logic [7:0] vb [2];
    logic [7:0] ex [2];
    va[0] = 8'h10; vb[0] = 8'h10; ex[0] = 8'h00;
    va[1] = 8'hFD; vb[1] = 8'h07; ex[1] = 8'hEB;
    ready8_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid8 = 1'b1;
      ctrl8 = MUL; a8 = va[i]; b8 = vb[i];
      tick();
      valid8 = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      checks++;
      if (valid8_o !== 1'b0) begin
        $display("FAIL mul8_early_%0d got=%b want=0", i, valid8_o);
        errors++;
      end
      tick();
      checks++;
      if (valid8_o !== 1'b1 || alu8_o !== ex[i] ||
          zero8_o !== (ex[i] == 8'h0)) begin
        $display("FAIL mul8_%0d got=%h/z%b/v%b want=%h/z%b/v1",
                 i, alu8_o, zero8_o, valid8_o, ex[i], ex[i] == 8'h0);
        errors++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    valid_i = 1'b1;
    ctrl = ADD; a = 32'd10; b = 32'd20;
    tick();
    ctrl = XOR_; a = 32'hF0; b = 32'hFF;
    checks++;
    if (valid_o !== 1'b1 || alu_o !== 32'd30) begin
      $display("FAIL bp_first got=%h/v%b want=0000001e/v1", alu_o, valid_o);
      errors++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 ||
          alu_o !== 32'd30 || zero_o !== 1'b0) begin
        $display("FAIL bp_hold_%0d got=%h/z%b/v%b/r%b want=1e/z0/v1/r0",
                 i, alu_o, zero_o, valid_o, ready_o);
        errors++;
      end
      tick();
    end
    ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || alu_o !== 32'h0F) begin
      $display("FAIL bp_xor got=%h/v%b want=0000000f/v1", alu_o, valid_o);
      errors++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1;
      ctrl = ADD; a = 32'd100; b = 32'(i);
      tick();
      checks++;
      if (valid_o !== 1'b1 || alu_o !== 32'(100 + i)) begin
        $display("FAIL b2b_%0d got=%h/v%b want=%h/v1",
                 i, alu_o, valid_o, 32'(100 + i));
        errors++;
      end
    end
    valid_i = 1'b0;
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      $display("FAIL b2b_fall got=%b want=0", valid_o);
      errors++;
    end
  endtask

  task automatic test_reset_mid_mul();
    int stale;
    ready_i = 1'b1;
    valid_i = 1'b1;
    ctrl = MUL; a = 32'h00012345; b = 32'h00006789;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (valid_o !== 1'b0 || alu_o !== 32'h0 || zero_o !== 1'b0) begin
      $display("FAIL midmul_reset got=%h/z%b/v%b want=0/z0/v0",
               alu_o, zero_o, valid_o);
      errors++;
    end
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o !== 1'b0) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin
      $display("FAIL midmul_stale got=%0d want=0 valid cycles", stale);
      errors++;
    end
    valid_i = 1'b1;
    ctrl = ADD; a = 32'd2; b = 32'd3;
    tick();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || alu_o !== 32'd5) begin
      $display("FAIL midmul_add got=%h/v%b want=00000005/v1", alu_o, valid_o);
      errors++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_mul8();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
